csa_accumulator: RTL

//  Multi-operand accumulator that keeps its running total in carry-save form: each accepted

---
 rtl/csa_acc_pkg.sv | 18 +
 rtl/csa_accumulator_if.sv | 38 +++
 rtl/csa_row.sv | 18 +
 rtl/csa_accumulator.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/csa_acc_pkg.sv
// Shared types and defaults for the carry-save accumulator.
package csa_acc_pkg;

   localparam int unsigned W_DEF     = 16;
   localparam int unsigned CHUNK_DEF = 4;

   typedef enum logic [1:0] {
      StAccum,
      StResolve,
      StOut
   } state_e;

   // Number of carry-propagate cycles needed to resolve a w-bit total.
   function automatic int unsigned num_chunks(input int unsigned w, input int unsigned chunk);
      return w / chunk;
   endfunction

endpackage

// File: rtl/csa_accumulator_if.sv
// Operand/result handshake bundle for csa_accumulator.
// in_sub is only present when CSA_ACC_SUB_EN is defined.
interface csa_accumulator_if #(
   parameter int unsigned W = csa_acc_pkg::W_DEF
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         in_last;
`ifdef CSA_ACC_SUB_EN
   logic         in_sub;
`endif
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic         busy;

`ifdef CSA_ACC_SUB_EN
   modport master (
      output in_valid, in_data, in_last, in_sub, out_ready,
      input  in_ready, out_valid, out_data, busy
   );
   modport slave (
      input  in_valid, in_data, in_last, in_sub, out_ready,
      output in_ready, out_valid, out_data, busy
   );
`else
   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, busy
   );
   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, busy
   );
`endif

endinterface

// File: rtl/csa_row.sv
// One row of W independent 3:2 full-adder cells: (s, c, d) -> (sum, majority).
module csa_row #(
   parameter int unsigned W = 16
) (
   input  logic [W-1:0] s,
   input  logic [W-1:0] c,
   input  logic [W-1:0] d,
   output logic [W-1:0] sum,
   output logic [W-1:0] maj
);

   // Bitwise full adders; no carry ripples between cells.
   always_comb begin
      sum = s ^ c ^ d;
      maj = (s & c) | (s & d) | (c & d);
   end

endmodule

// File: rtl/csa_accumulator.sv
// Multi-operand accumulator holding its running total in carry-save form.
// Each accepted operand goes through one csa_row; the last operand of a group
// triggers a chunked carry-propagate resolve of W/CHUNK cycles.
// Optional feature macro: CSA_ACC_SUB_EN (adds in_sub, subtract via ~d plus carry LSB).
// W must be a multiple of CHUNK and at least 2.
module csa_accumulator
   import csa_acc_pkg::*;
#(
   parameter int unsigned W     = W_DEF,
   parameter int unsigned CHUNK = CHUNK_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   csa_accumulator_if.slave  bus
);

   localparam int unsigned NCHUNK = num_chunks(W, CHUNK);
   localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   state_e          state_q, state_d;
   logic [W-1:0]    sum_q, sum_d;
   logic [W-1:0]    carry_q, carry_d;
   logic [W-1:0]    res_q, res_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            ci_q, ci_d;
   logic            out_valid_q, out_valid_d;
   logic [W-1:0]    out_data_q, out_data_d;

   logic [W-1:0]    d;
   logic            inj;
   logic [W-1:0]    row_sum, row_maj;
   logic [CHUNK-1:0] s_chunk, c_chunk;
   logic [CHUNK:0]  chunk_sum;
   logic            last_chunk;
   logic            accept;

`ifdef CSA_ACC_SUB_EN
   // Subtract as ~d + 1; the +1 rides in the carry LSB that the shift leaves free.
   assign d   = bus.in_sub ? ~bus.in_data : bus.in_data;
   assign inj = bus.in_sub;
`else
   assign d   = bus.in_data;
   assign inj = 1'b0;
`endif

   csa_row #(
      .W (W)
   ) u_row (
      .s   (sum_q),
      .c   (carry_q),
      .d   (d),
      .sum (row_sum),
      .maj (row_maj)
   );

   assign accept     = bus.in_valid && (state_q == StAccum);
   assign last_chunk = (cnt_q == CW'(NCHUNK - 1));

   // Chunk adder for the resolve phase, selected by the chunk counter.
   always_comb begin
      s_chunk   = sum_q[cnt_q*CHUNK +: CHUNK];
      c_chunk   = carry_q[cnt_q*CHUNK +: CHUNK];
      chunk_sum = {1'b0, s_chunk} + {1'b0, c_chunk} + {{CHUNK{1'b0}}, ci_q};
   end

   // Next-state and datapath update.
   always_comb begin
      state_d     = state_q;
      sum_d       = sum_q;
      carry_d     = carry_q;
      res_d       = res_q;
      cnt_d       = cnt_q;
      ci_d        = ci_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      unique case (state_q)
         StAccum: begin
            if (accept) begin
               sum_d   = row_sum;
               // Majority MSB drops out: the total is kept modulo 2^W.
               carry_d = {row_maj[W-2:0], inj};
               if (bus.in_last) begin
                  state_d = StResolve;
                  cnt_d   = '0;
                  ci_d    = 1'b0;
               end
            end
         end
         StResolve: begin
            res_d[cnt_q*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
            ci_d = chunk_sum[CHUNK];
            if (last_chunk) begin
               out_data_d  = res_d;
               out_valid_d = 1'b1;
               state_d     = StOut;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         StOut: begin
            if (bus.out_ready) begin
               sum_d       = '0;
               carry_d     = '0;
               res_d       = '0;
               out_valid_d = 1'b0;
               state_d     = StAccum;
            end
         end
         default: state_d = StAccum;
      endcase
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StAccum;
         sum_q       <= '0;
         carry_q     <= '0;
         res_q       <= '0;
         cnt_q       <= '0;
         ci_q        <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         sum_q       <= sum_d;
         carry_q     <= carry_d;
         res_q       <= res_d;
         cnt_q       <= cnt_d;
         ci_q        <= ci_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign bus.in_ready  = (state_q == StAccum);
   assign bus.busy      = (state_q != StAccum);
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;

endmodule
